// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM encodings, round count and the inverse-cipher
// byte/word transforms used by the decrypt datapath.
package aes_pkg;

    localparam int AES_NR = 14;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_INIT  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_FINAL = 2'd3;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // Byte k of a block sits at bits [127-8k -: 8]; byte 4c+r is row r, column c.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*((c+r)%4)+r) -: 8] = s[127-8*(4*c+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
            o[119-32*c -: 8] = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
            o[111-32*c -: 8] = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
            o[103-32*c -: 8] = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box; the table is packed with entry 0 in the
// top byte so entry x lives at bit offset (255-x)*8 = {~x, 3'b000}.
module inv_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign out_byte = INV_SBOX[{~in_byte, 3'b000} +: 8];

endmodule

// File: rtl/aes256_decrypt_core.sv
// Iterative AES-256 inverse cipher, one round per clock, reading round keys
// 14 down to 0 from an external key store through rk_idx/rk_data.
module aes256_decrypt_core
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] ciphertext,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         busy,
    output logic         done,
    output logic [127:0] plaintext
);

    logic [1:0]   state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] st_q, st_d;
    logic [127:0] pt_q, pt_d;
    logic         done_q, done_d;

    logic [127:0] isr_st;
    logic [127:0] sb_out;

    // ROUND and FINAL share the InvShiftRows -> InvSubBytes front end.
    assign isr_st = inv_shift_rows(st_q);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .in_byte  (isr_st[127-8*i -: 8]),
            .out_byte (sb_out[127-8*i -: 8])
        );
    end

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        ct_d    = ct_q;
        st_d    = st_q;
        pt_d    = pt_q;
        done_d  = 1'b0;
        rk_idx  = 4'(NR);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ct_d    = ciphertext;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                st_d    = ct_q ^ rk_data;
                rnd_d   = 4'(NR - 1);
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                rk_idx = rnd_q;
                st_d   = inv_mix_columns(sb_out ^ rk_data);
                // rnd stops at 1 so it never wraps below the valid range.
                if (rnd_q == 4'd1) begin
                    state_d = ST_FINAL;
                end else begin
                    rnd_d = rnd_q - 4'd1;
                end
            end
            ST_FINAL: begin
                rk_idx  = 4'd0;
                pt_d    = sb_out ^ rk_data;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rnd_q   <= '0;
            ct_q    <= '0;
            st_q    <= '0;
            pt_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            ct_q    <= ct_d;
            st_q    <= st_d;
            pt_q    <= pt_d;
            done_q  <= done_d;
        end
    end

    // busy drops on the same edge that raises done, so the two never overlap.
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign plaintext = pt_q;

endmodule

// File: doc/aes256_decrypt_core.md
# aes256_decrypt_core

Iterative AES-256 inverse cipher (FIPS-197 InvCipher) that recovers a 128-bit plaintext block from a ciphertext block, one round per clock. It is the decrypt-side counterpart of the encryption datapath. It reads pre-expanded round keys from the shared key-expansion store through an index/data port, in reverse order (14 down to 0). It does not expand keys itself.

## Interface
Parameters:
- NR, 14, number of AES rounds (fixed for AES-256; not to be overridden)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- ciphertext  in  128  input block; captured on the accepted start edge; byte 0 = bits [127:120], column-major per FIPS-197
- rk_idx  out  4  round-key index requested this cycle (combinational from state)
- rk_data  in  128  round key for rk_idx; combinational read, valid in the same cycle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when plaintext is valid
- plaintext  out  128  result; holds until the next done or reset

## Operation
- States: IDLE, INIT, ROUND, FINAL.
- IDLE: rk_idx=14, busy=0. If start=1, capture ciphertext into ct_reg and go to INIT.
- INIT: rk_idx=14. Set st <= ct_reg ^ rk_data. Set rnd <= 13. Go to ROUND.
- ROUND: rk_idx=rnd.
  - Compute st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk_data).
  - If rnd==1, go to FINAL. Otherwise rnd <= rnd-1 and stay in ROUND.
- FINAL: rk_idx=0.
  - Compute plaintext <= InvSubBytes(InvShiftRows(st)) ^ rk_data.
  - Pulse done=1 and go to IDLE.
- InvShiftRows: row r rotates right by r byte positions (r=0..3).
- InvMixColumns: per column, multiply by the matrix [0e 0b 0d 09] (circulant) over GF(2^8), polynomial 0x11b. Products are built from repeated xtime.
- All arithmetic is byte-wide XOR/GF. There are no carries and no width growth.
- rnd is 4 bits and never wraps. It is valid only in 1..13 while in ROUND.

## Timing
- Reset values: busy=0, done=0, plaintext=0, rk_idx=14 (IDLE). Internal st, ct_reg and rnd are all cleared to 0.
- Latency: the start edge is cycle 0, the INIT update happens at edge 1, and the rounds occupy edges 2..14.
  - FINAL updates at edge 15, so done is high during the cycle after edge 15 (15 cycles after start).
- Throughput: one block per 16 cycles. A start held high in the same cycle as done is not seen; the next block is accepted at the first IDLE edge after done.
- start while busy is ignored. ciphertext changes while busy have no effect.
- rk_data must be stable for the cycle rk_idx presents an index. The core issues exactly the sequence 14,14,13..1,0.
- Reset mid-operation returns the core to IDLE immediately, clears outputs to their reset values, and drops the block. There is no done pulse.
- done and busy are never both high; busy falls at the same edge done rises.

## Structure
- The shared package aes_pkg holds:
  - state encodings (IDLE/INIT/ROUND/FINAL)
  - NR=14
  - GF functions xtime, gmul9, gmul11, gmul13, gmul14
  - InvShiftRows and InvMixColumns as functions on 128-bit words
- Sub-module inv_sbox: combinational 8-bit to 8-bit inverse S-box lookup, instantiated 16 times on the InvShiftRows output.
- The core holds the FSM, the round counter, ct_reg, st and the output register. Target is about 150-250 lines excluding inv_sbox.

## Test plan
- FIPS-197 C.3 vector:
  - Round keys come from key 000102…1e1f.
  - ciphertext 8ea2b7ca516745bfeafc49904b496089 -> plaintext 00112233445566778899aabbccddeeff.
  - done must pulse exactly 15 cycles after start.
- rk_idx trace: log rk_idx from start through done. It must equal 14,14,13,12,…,1,0, then 14 in IDLE.
- Back-to-back:
  - Assert start again on the first IDLE cycle after done, using a second ciphertext made by encrypting ffeeddccbbaa99887766554433221100.
  - The second done must carry that plaintext, and the first plaintext must hold until then.
- start while busy: pulse start with a different ciphertext at cycle 5. The result must still be 00112233…eeff and there must be no extra done.
- Mid-operation reset: assert rst at cycle 8.
  - busy, done and plaintext must go to 0 asynchronously.
  - A fresh start afterwards must produce the correct C.3 result.
- Round-trip: for 100 random blocks, the encryption core output fed through this block must return the original plaintext.
